// File: rtl/arm_pio_pkg.sv
// arm_pio_pkg: register map and edge-type encodings for the PIO input block
package arm_pio_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/arm_pio_debounce.sv
// arm_pio_debounce: single-bit debouncer, output follows input only after it differs for DEBOUNCE_CYCLES clocks
module arm_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      logic unused_clk;
      assign unused_clk = clk ^ reset_n;
      assign dout = din;
    end else begin : g_filt
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CW-1:0] cnt;
      // any sample that agrees with the output restarts the count
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
          cnt  <= '0;
          dout <= 1'b0;
        end else if (din == dout) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt  <= '0;
          dout <= din;
        end else begin
          cnt <= cnt + 1'b1;
        end
    end
  endgenerate
endmodule

// File: rtl/arm_pio_in.sv
// arm_pio_in: Avalon-MM PIO input port with synchronizer, debounce, edge capture and masked interrupt
module arm_pio_in
  import arm_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] sync1, sync2, deb, prev, mask, capture, edges, rd_sel;
  logic wr;
  assign wr = chipselect & ~write_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_deb
      arm_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sync2[i]),
        .dout    (deb[i])
      );
    end
    if (WIDTH < 32) begin : g_unused
      logic unused_wd;
      assign unused_wd = ^writedata[31:WIDTH];
    end
  endgenerate
  assign edges = EDGE_TYPE == EDGE_FALL ? ~deb & prev :
                 EDGE_TYPE == EDGE_ANY  ? deb ^ prev  : deb & ~prev;
  // a freshly detected edge outranks a same-cycle clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev    <= '0;
      mask    <= '0;
      capture <= '0;
    end else begin
      prev    <= deb;
      if (wr && address == ADDR_MASK) mask <= writedata[WIDTH-1:0];
      capture <= (wr && address == ADDR_EDGE ? capture & ~writedata[WIDTH-1:0] : capture) | edges;
    end
  always_comb begin
    rd_sel   = address == ADDR_DATA ? deb :
               address == ADDR_MASK ? mask :
               address == ADDR_EDGE ? capture : '0;
    readdata = 32'(rd_sel);
  end
  assign irq = |(capture & mask);
endmodule

// File: tb/tb_arm_pio_in.sv
// tb_arm_pio_in: randomized check of three PIO configurations against a window-based reference model
module tb_arm_pio_in;
  localparam int NI = 3;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic [31:0] rd [NI];
  logic        irq [NI];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arm_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq[0]));
  arm_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq[1]));
  arm_pio_in #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq[2]));

  function automatic int et(int k);
    return k == 0 ? 0 : k == 1 ? 2 : 1;
  endfunction
  function automatic int dc(int k);
    return k == 0 ? 0 : k == 1 ? 4 : 2;
  endfunction

  logic [7:0] m_s1 [NI], m_s2 [NI], m_deb [NI], m_prev [NI], m_cap [NI], m_mask [NI];
  logic [7:0] m_hist [NI][4];
  int m_hn [NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_s1[k] = '0; m_s2[k] = '0; m_deb[k] = '0; m_prev[k] = '0; m_cap[k] = '0; m_mask[k] = '0;
      m_hn[k] = 0;
      for (int j = 0; j < 4; j++) m_hist[k][j] = '0;
    end
  endtask

  function automatic logic [7:0] deb_view(int k);
    return dc(k) == 0 ? m_s2[k] : m_deb[k];
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [1:0] a);
    logic [7:0] v;
    v = a == 2'd0 ? deb_view(k) : a == 2'd2 ? m_mask[k] : a == 2'd3 ? m_cap[k] : 8'h00;
    return {24'h0, v};
  endfunction

  function automatic logic exp_irq(int k);
    return |(m_cap[k] & m_mask[k]);
  endfunction

  // deb flips once the last D synchronized samples all disagree with it
  task automatic model_step(input logic [7:0] din, input logic [1:0] a, input logic c, input logic wn,
                            input logic [31:0] wd);
    logic [7:0] dv, eg, nd;
    logic wr, ok;
    wr = c && !wn;
    for (int k = 0; k < NI; k++) begin
      dv = deb_view(k);
      eg = et(k) == 1 ? (~dv & m_prev[k]) : et(k) == 2 ? (dv ^ m_prev[k]) : (dv & ~m_prev[k]);
      nd = m_deb[k];
      if (dc(k) > 0) begin
        for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = m_s2[k];
        if (m_hn[k] < 4) m_hn[k]++;
        if (m_hn[k] >= dc(k))
          for (int b = 0; b < 8; b++) begin
            ok = 1'b1;
            for (int j = 0; j < dc(k); j++) if (m_hist[k][j][b] == m_deb[k][b]) ok = 1'b0;
            if (ok) nd[b] = ~m_deb[k][b];
          end
      end
      m_prev[k] = dv;
      m_cap[k]  = ((wr && a == 2'd3) ? (m_cap[k] & ~wd[7:0]) : m_cap[k]) | eg;
      if (wr && a == 2'd2) m_mask[k] = wd[7:0];
      m_deb[k] = nd;
      m_s2[k]  = m_s1[k];
      m_s1[k]  = din;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic tick(input logic [7:0] din, input logic [1:0] a, input logic c, input logic wn,
                      input logic [31:0] wd);
    in_port = din; address = a; chipselect = c; write_n = wn; writedata = wd;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rd u%0d a%0d", k, a), rd[k], exp_rd(k, a));
      chk($sformatf("irq u%0d", k), {31'b0, irq[k]}, {31'b0, exp_irq(k)});
    end
    @(posedge clk);
    model_step(din, a, c, wn, wd);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      for (int k = 0; k < NI; k++) chk($sformatf("%s rd u%0d a%0d", tag, k, a), rd[k], 32'h0);
    end
    for (int k = 0; k < NI; k++) chk($sformatf("%s irq u%0d", tag, k), {31'b0, irq[k]}, 32'h0);
  endtask

  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) chk($sformatf("async irq u%0d", k), {31'b0, irq[k]}, 32'h0);
    check_zero("in_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] cur;
    int hold;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("por");
    @(negedge clk);
    reset_n = 1'b1;
    tick(8'h00, 2'd2, 1'b1, 1'b0, 32'h4);
    repeat (6) tick(8'h05, 2'd0, 1'b1, 1'b1, 32'h0);
    repeat (2) tick(8'h05, 2'd3, 1'b1, 1'b1, 32'h0);
    tick(8'h05, 2'd3, 1'b1, 1'b0, 32'h4);
    repeat (2) tick(8'h05, 2'd3, 1'b0, 1'b1, 32'h0);
    cur = 8'h00;
    hold = 1;
    for (int n = 0; n < 1500; n++) begin
      logic [1:0] a;
      logic [31:0] wd;
      if (--hold == 0) begin
        cur = ($urandom_range(0, 3) == 0) ? 8'($urandom) : cur ^ (8'h1 << $urandom_range(0, 7));
        hold = $urandom_range(1, 8);
      end
      a  = 2'($urandom);
      wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      if (n == 700 || n == 1200) begin
        tick(cur, 2'd2, 1'b1, 1'b0, 32'hFF);
        mid_reset();
      end else begin
        tick(cur, a, 1'($urandom), ($urandom_range(0, 4) != 0), wd);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
